// File: rtl/freq_gen_pkg.sv
// Shared encodings and constants for the frequency generator and its phase accumulator.
package freq_gen_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX             = 4'd9;
    localparam int         N_WIDTH               = 7;
    localparam int         DEFAULT_UPDATE_PERIOD = 1200;
endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator: adds step each advance and wraps at UPDATE_PERIOD, flagging a toggle on wrap.
module phase_accumulator
    import freq_gen_pkg::*;
#(
    parameter int UPDATE_PERIOD = DEFAULT_UPDATE_PERIOD,
    parameter int BITS          = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    input  logic [N_WIDTH:0] step,
    output logic             toggle
);
    localparam logic [BITS:0] PERIOD = (BITS+1)'(UPDATE_PERIOD);

    logic [BITS-1:0] acc_q, acc_d;
    logic [BITS:0]   sum;

    always_comb begin
        sum    = {1'b0, acc_q} + (BITS+1)'(step);
        toggle = 1'b0;
        acc_d  = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (advance) begin
            // Subtracting the period keeps the remainder, so the phase never drifts.
            if (sum >= PERIOD) begin
                toggle = 1'b1;
                acc_d  = BITS'(sum - PERIOD);
            end else begin
                acc_d  = BITS'(sum);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end
endmodule

// File: rtl/frequency_generator.sv
// Square-wave generator: N = 10*tens + units rising edges per UPDATE_PERIOD clocks.
// Optional window monitor (window/edges ports) enabled by FREQ_GEN_WINDOW_MON_EN.
module frequency_generator
    import freq_gen_pkg::*;
#(
    parameter int UPDATE_PERIOD = DEFAULT_UPDATE_PERIOD,
    parameter int BITS          = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    input  logic       load,
    output logic       signal,
`ifdef FREQ_GEN_WINDOW_MON_EN
    output logic       window,
    output logic [6:0] edges,
`endif
    output logic       busy,
    output logic       error
);
    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] n_q, n_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               signal_q, signal_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;
    logic               load_req, load_ok, advance, toggle;

    phase_accumulator #(.UPDATE_PERIOD(UPDATE_PERIOD), .BITS(BITS)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear   (load_ok),
        .advance (advance),
        .step    ({n_q, 1'b0}),
        .toggle  (toggle)
    );

    always_comb begin
        load_req = load && !busy_q;
        load_ok  = load_req && (tens <= DIGIT_MAX) && (units <= DIGIT_MAX);
        advance  = (state_q == ST_RUN) && !load_ok;
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        signal_d = signal_q;
        error_d  = error_q;
        case (state_q)
            ST_IDLE: ;
            ST_CONVERT: begin
                // BCD to binary by repeated +10, one tens step per clock.
                if (cnt_q != 4'd0) begin
                    n_d   = n_q + N_WIDTH'(10);
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  if (toggle) signal_d = ~signal_q;
            default: begin
                state_d  = ST_IDLE;
                signal_d = 1'b0;
            end
        endcase
        if (load_ok) begin
            n_d      = N_WIDTH'(units);
            cnt_d    = tens;
            signal_d = 1'b0;
            error_d  = 1'b0;
            state_d  = ST_CONVERT;
        end else if (load_req) begin
            error_d  = 1'b1;
        end
        busy_d = (state_d == ST_CONVERT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            signal_q <= 1'b0;
            busy_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            signal_q <= signal_d;
            busy_q   <= busy_d;
            error_q  <= error_d;
        end
    end

    assign signal = signal_q;
    assign busy   = busy_q;
    assign error  = error_q;

`ifdef FREQ_GEN_WINDOW_MON_EN
    localparam logic [BITS-1:0] WLAST = BITS'(UPDATE_PERIOD - 1);

    logic [BITS-1:0] wcnt_q, wcnt_d;
    logic [6:0]      ecnt_q, ecnt_d;
    logic [6:0]      edges_q, edges_d;
    logic            window_q, window_d;
    logic            rise;

    always_comb begin
        rise     = advance && toggle && !signal_q;
        wcnt_d   = wcnt_q;
        ecnt_d   = ecnt_q;
        edges_d  = edges_q;
        window_d = 1'b0;
        if (load_ok) begin
            wcnt_d  = '0;
            ecnt_d  = '0;
            edges_d = '0;
        end else if (advance) begin
            // The edge on the wrapping clock still belongs to the closing window.
            if (wcnt_q == WLAST) begin
                wcnt_d   = '0;
                ecnt_d   = '0;
                edges_d  = ecnt_q + 7'(rise);
                window_d = 1'b1;
            end else begin
                wcnt_d   = wcnt_q + 1'b1;
                ecnt_d   = ecnt_q + 7'(rise);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q   <= '0;
            ecnt_q   <= '0;
            edges_q  <= '0;
            window_q <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            ecnt_q   <= ecnt_d;
            edges_q  <= edges_d;
            window_q <= window_d;
        end
    end

    assign window = window_q;
    assign edges  = edges_q;
`endif
endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: reset, BCD load, periods, edge counts, error and load corner cases.
module tb_frequency_generator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] tens = 4'd0;
    logic [3:0] units = 4'd0;
    logic       load = 1'b0;
    logic       signal, busy, error;
`ifdef FREQ_GEN_WINDOW_MON_EN
    logic       window;
    logic [6:0] edges;
`endif
    int errors = 0;
    int checks = 0;

    frequency_generator dut (
        .clk    (clk),
        .reset  (reset),
        .tens   (tens),
        .units  (units),
        .load   (load),
        .signal (signal),
`ifdef FREQ_GEN_WINDOW_MON_EN
        .window (window),
        .edges  (edges),
`endif
        .busy   (busy),
        .error  (error)
    );

    always #5 clk = ~clk;

    // Called on a negedge; load is sampled by exactly one posedge.
    task automatic do_load(input logic [3:0] t, input logic [3:0] u);
        tens = t; units = u; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Counts negedges with busy high, starting at the current one.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (signal !== lvl && n < 3000);
    endtask

    task automatic count_rising(input int cycles, output int n);
        logic prev;
        n = 0;
        prev = signal;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (signal === 1'b1 && prev === 1'b0) n++;
            prev = signal;
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (signal !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: signal=%b busy=%b error=%b expected 000", signal, busy, error);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_slow;
        int n;
        do_load(4'd0, 4'd1);
        count_busy(n);
        checks++;
        if (n != 1) begin errors++; $display("FAIL busy_len_01: got %0d expected 1", n); end
        wait_level(1'b1, n);
        checks++;
        if (n != 600) begin errors++; $display("FAIL first_rise_01: got %0d expected 600", n); end
        wait_level(1'b0, n);
        checks++;
        if (n != 600) begin errors++; $display("FAIL high_len_01: got %0d expected 600", n); end
        wait_level(1'b1, n);
        checks++;
        if (n != 600) begin errors++; $display("FAIL low_len_01: got %0d expected 600", n); end
    endtask

    task automatic test_fast;
        int n;
        do_load(4'd9, 4'd9);
        count_busy(n);
        checks++;
        if (n != 10) begin errors++; $display("FAIL busy_len_99: got %0d expected 10", n); end
        for (int w = 0; w < 2; w++) begin
            count_rising(1200, n);
            checks++;
            if (n != 99) begin errors++; $display("FAIL edges_99_w%0d: got %0d expected 99", w, n); end
        end
`ifdef FREQ_GEN_WINDOW_MON_EN
        n = 0;
        while (window !== 1'b1 && n < 1300) begin @(negedge clk); n++; end
        checks++;
        if (window !== 1'b1 || edges !== 7'd99) begin
            errors++;
            $display("FAIL mon_edges_99: window=%b edges=%0d expected 1/99", window, edges);
        end
`endif
    endtask

    task automatic test_error;
        int n;
        do_load(4'd10, 4'd3);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_tens: error=%b busy=%b expected 1/0", error, busy);
        end
        count_rising(1200, n);
        checks++;
        if (n != 99) begin errors++; $display("FAIL edges_after_bad: got %0d expected 99", n); end
        do_load(4'd4, 4'd2);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL good_clears_err: error=%b busy=%b expected 0/1", error, busy);
        end
        count_busy(n);
        checks++;
        if (n != 5) begin errors++; $display("FAIL busy_len_42: got %0d expected 5", n); end
        count_rising(1200, n);
        checks++;
        if (n != 42) begin errors++; $display("FAIL edges_42: got %0d expected 42", n); end
        do_load(4'd3, 4'd15);
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL bad_units: error=%b expected 1", error); end
        count_rising(1200, n);
        checks++;
        if (n != 42) begin errors++; $display("FAIL edges_after_bad_units: got %0d expected 42", n); end
    endtask

    task automatic test_reset_mid_run;
        int n;
        wait_level(1'b1, n);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (signal !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: signal=%b busy=%b error=%b expected 000", signal, busy, error);
        end
        @(negedge clk);
        reset = 1'b0;
        count_rising(700, n);
        checks++;
        if (n != 0 || signal !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: edges=%0d signal=%b expected 0/0", n, signal);
        end
    endtask

    task automatic test_busy_load;
        int n;
        do_load(4'd5, 4'd0);
        do_load(4'd0, 4'd1);
        count_busy(n);
        n = n + 1;
        checks++;
        if (n != 6 || error !== 1'b0) begin
            errors++;
            $display("FAIL load_during_busy: busy_len=%0d error=%b expected 6/0", n, error);
        end
        count_rising(1200, n);
        checks++;
        if (n != 50) begin errors++; $display("FAIL edges_50: got %0d expected 50", n); end
    endtask

    task automatic test_load_on_toggle;
        int n;
        do_load(4'd0, 4'd1);
        count_busy(n);
        repeat (599) @(negedge clk);
        checks++;
        if (signal !== 1'b0) begin errors++; $display("FAIL pre_toggle: signal=%b expected 0", signal); end
        do_load(4'd0, 4'd2);
        checks++;
        if (signal !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL load_beats_toggle: signal=%b busy=%b expected 0/1", signal, busy);
        end
        count_busy(n);
        wait_level(1'b1, n);
        checks++;
        if (n != 300) begin errors++; $display("FAIL first_rise_02: got %0d expected 300", n); end
        wait_level(1'b0, n);
        checks++;
        if (n != 300) begin errors++; $display("FAIL high_len_02: got %0d expected 300", n); end
    endtask

    initial begin
        test_reset();
        test_slow();
        test_fast();
        test_error();
        test_reset_mid_run();
        test_busy_load();
        test_load_on_toggle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
